// File: rtl/rob_multi_port_if.sv
// Dispatch, writeback, commit and recovery signals of the multi-port
// reorder buffer. The master side is the pipeline, the slave side the ROB.
interface rob_multi_port_if #(
    parameter int ADDR_WIDTH     = 3,
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int EXC_WIDTH      = 4,
    parameter int PC_WIDTH       = 32
);
    // dispatch
    logic                      write_en;
    logic                      write_reg_write_en_in;
    logic [REG_ADDR_WIDTH-1:0] write_reg_write_addr_in;
    logic [EXC_WIDTH-1:0]      write_exception_type_in;
    logic                      write_is_delayslot_in;
    logic [PC_WIDTH-1:0]       write_pc_in;
    logic                      can_write;
    logic [ADDR_WIDTH-1:0]     write_rob_addr_out;
    // writeback
    logic                      update0_en,   update1_en;
    logic [ADDR_WIDTH-1:0]     update0_addr, update1_addr;
    logic [DATA_WIDTH-1:0]     update0_data, update1_data;
    logic [EXC_WIDTH-1:0]      update0_exc,  update1_exc;
    // commit
    logic                      commit0_en, commit1_en;
    logic                      can_commit0, can_commit1;
    logic                      commit0_reg_write_en,   commit1_reg_write_en;
    logic [REG_ADDR_WIDTH-1:0] commit0_reg_write_addr, commit1_reg_write_addr;
    logic [DATA_WIDTH-1:0]     commit0_reg_write_data, commit1_reg_write_data;
    logic [EXC_WIDTH-1:0]      commit0_exception_type, commit1_exception_type;
    logic                      commit0_is_delayslot,   commit1_is_delayslot;
    logic [PC_WIDTH-1:0]       commit0_pc,             commit1_pc;
    // recovery
    logic                      erase_en;
    logic [ADDR_WIDTH-1:0]     erase_from_addr;
    logic                      flush_en;
    logic [ADDR_WIDTH:0]       count_out;

    modport master (
        output write_en, write_reg_write_en_in, write_reg_write_addr_in,
               write_exception_type_in, write_is_delayslot_in, write_pc_in,
               update0_en, update0_addr, update0_data, update0_exc,
               update1_en, update1_addr, update1_data, update1_exc,
               commit0_en, commit1_en, erase_en, erase_from_addr, flush_en,
        input  can_write, write_rob_addr_out, can_commit0, can_commit1,
               commit0_reg_write_en, commit0_reg_write_addr, commit0_reg_write_data,
               commit0_exception_type, commit0_is_delayslot, commit0_pc,
               commit1_reg_write_en, commit1_reg_write_addr, commit1_reg_write_data,
               commit1_exception_type, commit1_is_delayslot, commit1_pc, count_out
    );

    modport slave (
        input  write_en, write_reg_write_en_in, write_reg_write_addr_in,
               write_exception_type_in, write_is_delayslot_in, write_pc_in,
               update0_en, update0_addr, update0_data, update0_exc,
               update1_en, update1_addr, update1_data, update1_exc,
               commit0_en, commit1_en, erase_en, erase_from_addr, flush_en,
        output can_write, write_rob_addr_out, can_commit0, can_commit1,
               commit0_reg_write_en, commit0_reg_write_addr, commit0_reg_write_data,
               commit0_exception_type, commit0_is_delayslot, commit0_pc,
               commit1_reg_write_en, commit1_reg_write_addr, commit1_reg_write_data,
               commit1_exception_type, commit1_is_delayslot, commit1_pc, count_out
    );
endinterface

// File: rtl/rob_multi_port.sv
// Circular reorder buffer: one dispatch per cycle, two writeback ports,
// up to two in-order retirements per cycle, partial erase and full flush.
module rob_multi_port #(
    parameter int ADDR_WIDTH     = 3,
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int EXC_WIDTH      = 4,
    parameter int PC_WIDTH       = 32
) (
    input logic             clk,
    input logic             rst,
    rob_multi_port_if.slave bus
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam int AW    = ADDR_WIDTH;

    typedef struct packed {
        logic                      valid;
        logic                      done;
        logic                      reg_we;
        logic [REG_ADDR_WIDTH-1:0] reg_addr;
        logic [DATA_WIDTH-1:0]     data;
        logic [EXC_WIDTH-1:0]      exc;
        logic                      ds;
        logic [PC_WIDTH-1:0]       pc;
    } entry_t;

    entry_t        r_rob [DEPTH];
    logic [AW-1:0] r_head, r_tail;
    logic [AW:0]   r_count;

    logic [AW-1:0] w_head1, w_head2, w_erase_off;
    logic [AW:0]   w_erase_cnt, w_ncommit, w_count_next;
    entry_t        w_e0, w_e1;
    logic          w_can_write, w_can_commit0, w_can_commit1;
    logic          w_erase_ok, w_write_acc, w_commit0, w_commit1;
    logic          w_upd0_ok, w_upd1_ok;

    // Derive availability, accepted operations and the next occupancy count.
    always_comb begin
        w_head1       = r_head + AW'(1);
        w_head2       = r_head + AW'(2);
        w_e0          = r_rob[r_head];
        w_e1          = r_rob[w_head1];
        w_can_write   = (r_count != (AW+1)'(DEPTH));
        w_can_commit0 = w_e0.valid & w_e0.done;
        // Slot 1 retires only exception-free pairs, and never a branch whose
        // delay slot (head+2) would be left behind in the buffer.
        w_can_commit1 = w_can_commit0 & w_e1.valid & w_e1.done
                      & (w_e0.exc == '0) & (w_e1.exc == '0)
                      & ~(r_rob[w_head2].valid & r_rob[w_head2].ds);
        // Erase point measured from head; legal only inside [head, tail).
        w_erase_off   = bus.erase_from_addr - r_head;
        w_erase_ok    = bus.erase_en & ({1'b0, w_erase_off} < r_count);
        w_erase_cnt   = r_count - {1'b0, w_erase_off};
        w_write_acc   = bus.write_en & w_can_write & ~bus.flush_en & ~w_erase_ok;
        w_commit0     = bus.commit0_en & w_can_commit0 & ~bus.flush_en
                      & (~w_erase_ok | (w_erase_off != '0));
        w_commit1     = w_commit0 & bus.commit1_en & w_can_commit1
                      & (~w_erase_ok | (w_erase_off > AW'(1)));
        w_ncommit     = (AW+1)'(w_commit0) + (AW+1)'(w_commit1);
        // A slot being allocated this cycle is still invalid, so updates to it
        // drop out through the valid test; the tail compare makes that explicit.
        w_upd1_ok     = bus.update1_en & r_rob[bus.update1_addr].valid
                      & ~(w_write_acc & (bus.update1_addr == r_tail));
        w_upd0_ok     = bus.update0_en & r_rob[bus.update0_addr].valid
                      & ~(w_write_acc & (bus.update0_addr == r_tail))
                      & ~(bus.update1_en & (bus.update1_addr == bus.update0_addr));
        if (bus.flush_en)
            w_count_next = '0;
        else if (w_erase_ok)
            w_count_next = {1'b0, w_erase_off} - w_ncommit;
        else
            w_count_next = r_count + (AW+1)'(w_write_acc) - w_ncommit;
    end

    // Pointer and occupancy registers.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values computed above, regardless of block order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            r_count <= w_count_next;
            if (bus.flush_en) begin
                r_head <= '0;
                r_tail <= '0;
            end else begin
                r_head <= r_head + w_ncommit[AW-1:0];
                if (w_erase_ok)
                    r_tail <= bus.erase_from_addr;
                else if (w_write_acc)
                    r_tail <= r_tail + AW'(1);
            end
        end
    end

    // Entry storage: allocate, write back, retire, erase, flush.
    // NOTE: the payload is reset as well as the flags, because the commit
    // outputs read the head entry directly and must show zero out of reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) r_rob[i] <= '0;
        end else if (bus.flush_en) begin
            for (int i = 0; i < DEPTH; i++) r_rob[i].valid <= 1'b0;
        end else begin
            if (w_write_acc)
                r_rob[r_tail] <= '{valid: 1'b1, done: (bus.write_exception_type_in != '0),
                                   reg_we: bus.write_reg_write_en_in,
                                   reg_addr: bus.write_reg_write_addr_in, data: '0,
                                   exc: bus.write_exception_type_in,
                                   ds: bus.write_is_delayslot_in, pc: bus.write_pc_in};
            if (w_upd0_ok) begin
                r_rob[bus.update0_addr].data <= bus.update0_data;
                r_rob[bus.update0_addr].done <= 1'b1;
                if (bus.update0_exc != '0) r_rob[bus.update0_addr].exc <= bus.update0_exc;
            end
            if (w_upd1_ok) begin
                r_rob[bus.update1_addr].data <= bus.update1_data;
                r_rob[bus.update1_addr].done <= 1'b1;
                if (bus.update1_exc != '0) r_rob[bus.update1_addr].exc <= bus.update1_exc;
            end
            if (w_commit0) r_rob[r_head].valid  <= 1'b0;
            if (w_commit1) r_rob[w_head1].valid <= 1'b0;
            if (w_erase_ok) begin
                for (int i = 0; i < DEPTH; i++)
                    if ({1'b0, AW'(i) - bus.erase_from_addr} < w_erase_cnt)
                        r_rob[i].valid <= 1'b0;
            end
        end
    end

    // Combinational outputs straight from head, head+1 and the counters.
    always_comb begin
        bus.can_write              = w_can_write;
        bus.write_rob_addr_out     = r_tail;
        bus.count_out              = r_count;
        bus.can_commit0            = w_can_commit0;
        bus.can_commit1            = w_can_commit1;
        bus.commit0_reg_write_en   = w_e0.reg_we;
        bus.commit0_reg_write_addr = w_e0.reg_addr;
        bus.commit0_reg_write_data = w_e0.data;
        bus.commit0_exception_type = w_e0.exc;
        bus.commit0_is_delayslot   = w_e0.ds;
        bus.commit0_pc             = w_e0.pc;
        bus.commit1_reg_write_en   = w_e1.reg_we;
        bus.commit1_reg_write_addr = w_e1.reg_addr;
        bus.commit1_reg_write_data = w_e1.data;
        bus.commit1_exception_type = w_e1.exc;
        bus.commit1_is_delayslot   = w_e1.ds;
        bus.commit1_pc             = w_e1.pc;
    end
endmodule
